// File: rtl/apb_const_fetch_arb_if.sv
// Bundle of requester-side and APB-side signals for apb_const_fetch_arb.
// The master modport is the arbiter's view; slave is the clients/fabric view.
interface apb_const_fetch_arb_if #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDX_W-1:0] req_idx;
    logic [N_REQ-1:0]       done;
    logic [63:0]            rsp_data;
    logic                   rsp_err;
    logic                   psel;
    logic                   penable;
    logic [31:0]            paddr;
    logic [31:0]            prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        input  req, req_idx, prdata, pready, pslverr,
        output done, rsp_data, rsp_err, psel, penable, paddr
    );

    modport slave (
        output req, req_idx, prdata, pready, pslverr,
        input  done, rsp_data, rsp_err, psel, penable, paddr
    );
endinterface

// File: rtl/apb_const_fetch_arb.sv
// Round-robin shared APB reader of 64-bit constants (high word, then low word).
// Optional macro APB_ARB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT cycles.
module apb_const_fetch_arb #(
    parameter int          N_REQ     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          IDX_W     = 4,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    apb_const_fetch_arb_if.master bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_const_fetch_arb: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP_H, ACCESS_H, SETUP_L, ACCESS_L, RESP} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               err_q, err_d;
    logic               found;
    int                 cand;

    logic               psel_q, psel_d, penable_q, penable_d, rsp_err_q, rsp_err_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [63:0]        rsp_data_q, rsp_data_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        err_d      = err_q;
        found      = 1'b0;
        cand       = 0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                // Search starts just after the last winner, so priority rotates.
                for (int i = 1; i <= N_REQ; i++) begin
                    cand = int'(last_gnt_q) + i;
                    if (cand >= N_REQ) cand = cand - N_REQ;
                    if (!found && bus.req[cand]) begin
                        found = 1'b1;
                        gnt_d = GW'(cand);
                    end
                end
                if (found) begin
                    idx_d   = bus.req_idx[gnt_d*IDX_W +: IDX_W];
                    state_d = SETUP_H;
                end
            end
            SETUP_H: begin
                state_d = ACCESS_H;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS_H: begin
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        hi_d    = bus.prdata;
                        state_d = SETUP_L;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            SETUP_L: begin
                state_d = ACCESS_L;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS_L: begin
                if (bus.pready) begin
                    lo_d    = bus.prdata;
                    err_d   = bus.pslverr;
                    state_d = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered with it.
        psel_d    = state_d inside {SETUP_H, ACCESS_H, SETUP_L, ACCESS_L};
        penable_d = state_d inside {ACCESS_H, ACCESS_L};
        paddr_d   = paddr_q;
        if (state_d == SETUP_H)      paddr_d = BASE_ADDR + (32'(idx_d) << 1);
        else if (state_d == SETUP_L) paddr_d = BASE_ADDR + (32'(idx_d) << 1) + 32'd1;
        done_d     = (state_d == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_d) : '0;
        rsp_err_d  = (state_d == RESP) && err_d;
        rsp_data_d = ((state_d == RESP) && !err_d) ? {hi_d, lo_d} : 64'd0;
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= GW'(N_REQ - 1);
            idx_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            err_q      <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            done_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            err_q      <= err_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            done_q     <= done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.psel     = psel_q;
    assign bus.penable  = penable_q;
    assign bus.paddr    = paddr_q;
    assign bus.done     = done_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_apb_const_fetch_arb.sv
// Directed bench for apb_const_fetch_arb: vector table plus hand-written
// sequences for stuck slave / timeout and reset during a transfer.
module tb_apb_const_fetch_arb;
    localparam int N_REQ = 2;
    localparam int IDX_W = 4;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_const_fetch_arb_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus();

    apb_const_fetch_arb #(
        .N_REQ(N_REQ), .BASE_ADDR(32'h7000_0000), .IDX_W(IDX_W), .TIMEOUT(16)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  req;
        logic [3:0]  idx0;
        logic [3:0]  idx1;
        int          wait_st;
        bit          err_hi;
        bit          err_lo;
        logic [1:0]  exp_done;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_n;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cur_wait = 0;
    bit err_hi = 1'b0;
    bit err_lo = 1'b0;
    bit allow_abort = 1'b0;
    int viol = 0;
    logic [31:0] addr_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Constant ROM contents: pi-test and e words, everything else is ~addr.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h7000_0000: rom = 32'h0000_1234;
            32'h7000_0001: rom = 32'h5678_9ABC;
            32'h7000_0002: rom = 32'h4005_BF0A;
            32'h7000_0003: rom = 32'h8B14_5769;
            default:       rom = ~a;
        endcase
    endfunction

    // Slave model with programmable wait states, plus an ACCESS-hold monitor.
    initial begin
        int wcnt;
        logic prev_psel, prev_pen;
        logic [31:0] prev_addr;
        wcnt = 0; prev_psel = 1'b0; prev_pen = 1'b0; prev_addr = '0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        forever begin
            @(negedge pclk);
            if (prev_psel && prev_pen && !bus.pready && !allow_abort &&
                (!bus.psel || !bus.penable || bus.paddr !== prev_addr))
                viol++;
            prev_psel = bus.psel; prev_pen = bus.penable; prev_addr = bus.paddr;
            if (bus.psel && bus.penable) begin
                if (wcnt < cur_wait) begin
                    bus.pready = 1'b0; bus.pslverr = 1'b0; wcnt++;
                end else begin
                    bus.pready  = 1'b1;
                    bus.prdata  = rom(bus.paddr);
                    bus.pslverr = (err_hi && !bus.paddr[0]) || (err_lo && bus.paddr[0]);
                    addr_log.push_back(bus.paddr);
                end
            end else begin
                bus.pready = 1'b0; bus.pslverr = 1'b0; wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},     64'(bus.psel),    64'd0);
        check({tag, "_penable"},  64'(bus.penable), 64'd0);
        check({tag, "_paddr"},    64'(bus.paddr),   64'd0);
        check({tag, "_done"},     64'(bus.done),    64'd0);
        check({tag, "_rsp_data"}, bus.rsp_data,     64'd0);
        check({tag, "_rsp_err"},  64'(bus.rsp_err), 64'd0);
    endtask

    // Applies one vector from IDLE, waits for done, checks it, returns in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        bit got;
        cur_wait = v.wait_st; err_hi = v.err_hi; err_lo = v.err_lo;
        addr_log.delete();
        bus.req = v.req;
        bus.req_idx = {v.idx1, v.idx0};
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge pclk); lat++;
            @(negedge pclk);
            if (bus.done != '0) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_done"},      64'(bus.done),    64'(v.exp_done));
        check({tag, "_latency"},   64'(lat),         64'(v.exp_lat));
        check({tag, "_data"},      bus.rsp_data,     v.exp_data);
        check({tag, "_err"},       64'(bus.rsp_err), 64'(v.exp_err));
        check({tag, "_psel_low"},  64'(bus.psel),    64'd0);
        check({tag, "_n_access"},  64'(addr_log.size()), 64'(v.exp_n));
        if (addr_log.size() > 0) check({tag, "_addr_h"}, 64'(addr_log[0]), 64'(v.exp_a0));
        if (addr_log.size() > 1) check({tag, "_addr_l"}, 64'(addr_log[1]), 64'(v.exp_a1));
        @(posedge pclk);
        @(negedge pclk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        bus.req = '0;
    endtask

    initial begin
        vec_t vecs[7];
        vec_t post;
        int   dcnt;
        int   lat;
        bit   got;

        vecs[0] = '{req:2'b11, idx0:4'd0,  idx1:4'd15, wait_st:0, err_hi:0, err_lo:0, exp_done:2'b01,
                    exp_data:64'h0000_1234_5678_9ABC, exp_err:0, exp_lat:5,  exp_n:2,
                    exp_a0:32'h7000_0000, exp_a1:32'h7000_0001};
        vecs[1] = '{req:2'b11, idx0:4'd0,  idx1:4'd15, wait_st:0, err_hi:0, err_lo:0, exp_done:2'b10,
                    exp_data:64'h8FFF_FFE1_8FFF_FFE0, exp_err:0, exp_lat:5,  exp_n:2,
                    exp_a0:32'h7000_001E, exp_a1:32'h7000_001F};
        vecs[2] = '{req:2'b11, idx0:4'd0,  idx1:4'd15, wait_st:0, err_hi:0, err_lo:0, exp_done:2'b01,
                    exp_data:64'h0000_1234_5678_9ABC, exp_err:0, exp_lat:5,  exp_n:2,
                    exp_a0:32'h7000_0000, exp_a1:32'h7000_0001};
        vecs[3] = '{req:2'b10, idx0:4'd0,  idx1:4'd1,  wait_st:3, err_hi:0, err_lo:0, exp_done:2'b10,
                    exp_data:64'h4005_BF0A_8B14_5769, exp_err:0, exp_lat:11, exp_n:2,
                    exp_a0:32'h7000_0002, exp_a1:32'h7000_0003};
        vecs[4] = '{req:2'b01, idx0:4'd5,  idx1:4'd0,  wait_st:0, err_hi:1, err_lo:0, exp_done:2'b01,
                    exp_data:64'd0, exp_err:1, exp_lat:3,  exp_n:1,
                    exp_a0:32'h7000_000A, exp_a1:32'h0};
        vecs[5] = '{req:2'b10, idx0:4'd0,  idx1:4'd5,  wait_st:0, err_hi:0, err_lo:1, exp_done:2'b10,
                    exp_data:64'd0, exp_err:1, exp_lat:5,  exp_n:2,
                    exp_a0:32'h7000_000A, exp_a1:32'h7000_000B};
        vecs[6] = '{req:2'b01, idx0:4'd15, idx1:4'd0,  wait_st:1, err_hi:0, err_lo:0, exp_done:2'b01,
                    exp_data:64'h8FFF_FFE1_8FFF_FFE0, exp_err:0, exp_lat:7,  exp_n:2,
                    exp_a0:32'h7000_001E, exp_a1:32'h7000_001F};
        post    = '{req:2'b10, idx0:4'd0,  idx1:4'd1,  wait_st:0, err_hi:0, err_lo:0, exp_done:2'b10,
                    exp_data:64'h4005_BF0A_8B14_5769, exp_err:0, exp_lat:5,  exp_n:2,
                    exp_a0:32'h7000_0002, exp_a1:32'h7000_0003};

        preset = 1'b1;
        bus.req = '0;
        bus.req_idx = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("reset");
        preset = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Slave that never answers.
        cur_wait = 1000; err_hi = 1'b0; err_lo = 1'b0;
        addr_log.delete();
        bus.req = 2'b01;
        bus.req_idx = 8'h00;
`ifdef APB_ARB_TIMEOUT_EN
        allow_abort = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge pclk); lat++;
            @(negedge pclk);
            if (bus.done != '0) got = 1'b1;
        end
        check("tmo_done_seen", 64'(got), 64'd1);
        check("tmo_latency",   64'(lat), 64'd18);
        check("tmo_done",      64'(bus.done), 64'h1);
        check("tmo_err",       64'(bus.rsp_err), 64'd1);
        check("tmo_data",      bus.rsp_data, 64'd0);
        check("tmo_psel",      64'(bus.psel), 64'd0);
        @(posedge pclk);
        @(negedge pclk);
        bus.req = '0;
        check("tmo_psel_after", 64'(bus.psel), 64'd0);
        check("tmo_done_pulse", 64'(bus.done), 64'd0);
        allow_abort = 1'b0;
`else
        dcnt = 0;
        repeat (40) begin
            @(posedge pclk);
            @(negedge pclk);
            if (bus.done != '0) dcnt++;
        end
        check("stuck_psel",    64'(bus.psel),    64'd1);
        check("stuck_penable", 64'(bus.penable), 64'd1);
        check("stuck_no_done", 64'(dcnt),        64'd0);
        check("stuck_paddr",   64'(bus.paddr),   64'h7000_0000);
        cur_wait = 0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge pclk); lat++;
            @(negedge pclk);
            if (bus.done != '0) got = 1'b1;
        end
        check("stuck_release_done", 64'(got), 64'd1);
        check("stuck_release_data", bus.rsp_data, 64'h0000_1234_5678_9ABC);
        check("stuck_release_err",  64'(bus.rsp_err), 64'd0);
        @(posedge pclk);
        @(negedge pclk);
        bus.req = '0;
`endif
        cur_wait = 0;
        @(negedge pclk);

        // Reset pulse while the low read is in its ACCESS phase.
        addr_log.delete();
        bus.req = 2'b01;
        bus.req_idx = 8'h00;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (bus.psel && bus.penable && bus.paddr == 32'h7000_0001) got = 1'b1;
        end
        check("rst_reached_access_l", 64'(got), 64'd1);
        preset = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("rst_mid");
        preset = 1'b0;
        bus.req = '0;
        dcnt = 0;
        repeat (8) begin
            @(posedge pclk);
            @(negedge pclk);
            if (bus.done != '0) dcnt++;
        end
        check("rst_no_done", 64'(dcnt), 64'd0);

        run_txn(post, "post_rst");

        check("access_hold_violations", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_const_fetch_arb.md
# apb_const_fetch_arb

Read-only APB master that shares the constant ROM slave at `BASE_ADDR` between `N_REQ` on-chip requesters. Each request names a 64-bit constant by index (0 = pi, 1 = e, …). The block arbitrates round-robin between requesters and sequences two APB reads (high word, then low word). It returns the assembled 64-bit word with a one-cycle done pulse. Instances sit between the compute clients and the APB fabric, in place of the testbench read task.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `BASE_ADDR`, 32'h7000_0000: slave base address.
- `IDX_W`, 4: width of the constant index per requester.
- `TIMEOUT`, 16: maximum cycles spent in an ACCESS state before the transfer is aborted (only with the macro).
- `pclk`  in  1: clock; every flop is on the rising edge.
- `preset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: request per requester; level, held until `done`.
- `req_idx`  in  N_REQ*IDX_W: constant index; slice i belongs to requester i and is stable while `req[i]` is high.
- `done`  out  N_REQ: one-cycle completion pulse, one-hot.
- `rsp_data`  out  64: {high word, low word}; valid while any `done` bit is high.
- `rsp_err`  out  1: error flag qualified by `done`.
- `psel`, `penable`  out  1: APB control.
- `paddr`  out  32: APB address.
- `prdata`  in  32: APB read data.
- `pready`, `pslverr`  in  1: APB response.

## Operation
- The FSM has six states: IDLE, SETUP_H, ACCESS_H, SETUP_L, ACCESS_L, RESP.
- IDLE: if any `req` is high, grant the first asserted requester after `last_gnt`, searching round-robin. Latch the grant index and `req_idx`. Next state is SETUP_H.
- SETUP_H: `psel`=1, `penable`=0, `paddr`=BASE_ADDR + 2*idx.
- ACCESS_H: `psel`=1, `penable`=1, `paddr` held. The state holds while `pready`=0.
  - On `pready`=1 with `pslverr`=0: capture `prdata` into the high register. Next state is SETUP_L.
  - On `pready`=1 with `pslverr`=1: set the error flag. Next state is RESP; the low read is skipped.
- SETUP_L / ACCESS_L: same as the high pair, with `paddr`=BASE_ADDR + 2*idx + 1. The low word is captured on `pready`=1. `pslverr` sets the error flag. Next state is RESP.
- RESP: `done[gnt]`=1, `psel`=0, `penable`=0. Update `last_gnt`=gnt. Next state is IDLE.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. `idx` is zero-extended.
- When `rsp_err`=1, `rsp_data` is 0.
- A requester that drops `req` mid-transaction does not abort it. The transaction completes and the `done` pulse is still issued.
- A new `req` that appears during a transaction waits for IDLE. No request is lost while it is held.
- Reset values: `psel`=0, `penable`=0, `paddr`=0, `done`=0, `rsp_data`=0, `rsp_err`=0, state=IDLE, `last_gnt`=N_REQ-1 (so requester 0 wins first).
- Reset asserted mid-transfer returns the block to IDLE on the next edge. `psel` and `penable` drop in that cycle. No `done` pulse is issued for the aborted request.

## Timing
- Let edge 0 be the edge at which IDLE samples `req`.
  - Cycle 1: SETUP_H.
  - Cycle 2: ACCESS_H.
  - Cycle 3: SETUP_L.
  - Cycle 4: ACCESS_L.
  - Cycle 5: `done`.
- With a zero-wait slave, latency from `req` sampled to `done` is 5 cycles. Each wait state adds 1 cycle.
- Each transaction ends with one RESP cycle and one IDLE cycle. Back-to-back transactions are therefore spaced 6 cycles apart, and `psel` is low for at least 2 cycles between them.
- `psel` stays high from SETUP_H through ACCESS_L.
- `prdata` is sampled only on an edge where `penable`=1 and `pready`=1.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter is cleared on entry to each ACCESS state.
  - If the counter reaches `TIMEOUT` with `pready` still 0, the block sets the error flag, goes to RESP and drops `psel` and `penable`.
- `APB_ARB_TIMEOUT_EN` undefined: there is no counter, and ACCESS waits indefinitely for `pready`.

## Test plan
- Single request, zero-wait slave: requester 0, idx 0; slave returns 32'h0000_1234 at 0x7000_0000 and 32'h5678_9ABC at 0x7000_0001. Required: `done[0]` 5 cycles later, `rsp_data`=64'h0000_1234_5678_9ABC, `rsp_err`=0.
- Wait states: idx 1 with 3 wait states on each read. Required: addresses 0x7000_0002 and 0x7000_0003, `done` 11 cycles after request, `psel`/`penable` stable throughout.
- Contention: `req`=2'b11 held for 3 fetches. Required grant order 0, 1, 0; each `done` is one-hot.
- Error on high read: `pslverr`=1 at 0x7000_0000. Required: no access to 0x7000_0001, `done` with `rsp_err`=1 and `rsp_data`=0.
- Timeout (macro defined, `TIMEOUT`=16): `pready` stuck at 0. Required: `done` with `rsp_err`=1 after 16 ACCESS cycles, then `psel`=0. With the macro undefined, `psel` remains 1.
- Reset mid-transfer: `preset` pulsed during ACCESS_L. Required: all outputs at reset values on the next cycle, no `done`; a subsequent request completes normally.
